// File: rtl/divalu.sv
// divalu -- iterative 32-bit signed/unsigned divider for DIV/DIVU.
//
// A restoring divider that works on operand magnitudes and produces one
// quotient bit per cycle, MSB first. Signs are fixed up in a single cycle
// after the last iteration. Results sit in registers and stay put until the
// next accepted request.
//
// Latency: start accepted at T, ITER T+1..T+32, FIX T+33, done at T+34.
// A zero divisor skips the iteration and reports done at T+1.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   reg_stall  EX stage stalled this cycle (only matters in DONE)
//   reg_flush  EX stage flushed; abandons any division in progress
//   start      current EX instruction is a DIV/DIVU
//   sign       1 = signed (DIV), 0 = unsigned (DIVU)
//   source_a   dividend
//   source_b   divisor
//   busy       division in progress; EX must stall (combinational)
//   done       quotient/remainder valid for the EX instruction
//   quotient   registered quotient (LO)
//   remainder  registered remainder (HI)
module divalu (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_stall,
  input  logic        reg_flush,
  input  logic        start,
  input  logic        sign,
  input  logic [31:0] source_a,
  input  logic [31:0] source_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int W_DATA = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_reg;
  logic [4:0]        count_reg;
  // Holds the remaining dividend bits; quotient bits shift in from the LSB
  // side as dividend bits leave from the MSB side.
  logic [W_DATA-1:0] dvd_reg;
  logic [W_DATA-1:0] dvs_reg;
  logic [W_DATA-1:0] rem_reg;
  logic              sign_reg;
  logic              a_neg_reg;
  logic              b_neg_reg;
  logic [W_DATA-1:0] quotient_reg;
  logic [W_DATA-1:0] remainder_reg;

  logic              accept;
  logic [W_DATA-1:0] a_abs;
  logic [W_DATA-1:0] b_abs;
  logic [W_DATA:0]   part_rem;
  logic [W_DATA:0]   diff;
  logic              q_bit;
  logic [W_DATA-1:0] rem_next;
  logic [W_DATA-1:0] quot_fix;
  logic [W_DATA-1:0] rem_fix;

  assign accept = (state_reg == S_IDLE) && start && !reg_flush;

  assign a_abs = (sign && source_a[W_DATA-1]) ? (~source_a + 32'd1) : source_a;
  assign b_abs = (sign && source_b[W_DATA-1]) ? (~source_b + 32'd1) : source_b;

  // 33-bit partial remainder: previous remainder shifted left with the next
  // dividend bit appended.
  assign part_rem = {rem_reg, dvd_reg[W_DATA-1]};
  assign diff     = part_rem - {1'b0, dvs_reg};
  // The previous remainder is always below the divisor, so a non-negative
  // difference fits in 32 bits; bit 32 of the difference is therefore a
  // clean borrow flag and doubles as the comparison result.
  assign q_bit    = ~diff[W_DATA];
  assign rem_next = q_bit ? diff[W_DATA-1:0] : part_rem[W_DATA-1:0];

  assign quot_fix = (sign_reg && (a_neg_reg ^ b_neg_reg)) ? (~dvd_reg + 32'd1) : dvd_reg;
  assign rem_fix  = (sign_reg && a_neg_reg) ? (~rem_reg + 32'd1) : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      count_reg     <= 5'd0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      sign_reg      <= 1'b0;
      a_neg_reg     <= 1'b0;
      b_neg_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else if (reg_flush) begin
      // Abandon whatever is in flight; result registers keep old values.
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            sign_reg  <= sign;
            a_neg_reg <= source_a[W_DATA-1];
            b_neg_reg <= source_b[W_DATA-1];
            dvd_reg   <= a_abs;
            dvs_reg   <= b_abs;
            rem_reg   <= '0;
            count_reg <= 5'd0;
            if (source_b == '0) begin
              // Divide by zero: all-ones quotient, dividend passed through.
              quotient_reg  <= '1;
              remainder_reg <= source_a;
              state_reg     <= S_DONE;
            end else begin
              state_reg <= S_ITER;
            end
          end
        end
        S_ITER: begin
          rem_reg   <= rem_next;
          dvd_reg   <= {dvd_reg[W_DATA-2:0], q_bit};
          count_reg <= count_reg + 5'd1;
          if (count_reg == 5'd31) begin
            state_reg <= S_FIX;
          end
        end
        S_FIX: begin
          quotient_reg  <= quot_fix;
          remainder_reg <= rem_fix;
          state_reg     <= S_DONE;
        end
        default: begin
          // DONE: hold while EX is stalled so the same instruction does not
          // retrigger; start is ignored here.
          if (!reg_stall) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = !rst && (accept || (state_reg == S_ITER) || (state_reg == S_FIX));
  assign done      = (state_reg == S_DONE);
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;

endmodule

// File: tb/tb_divalu.sv
// Self-checking bench for divalu: a table of divisions applied back-to-back
// through a result scoreboard, plus hand-written flush, stall and reset
// sequences.
module tb_divalu;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_stall;
  logic        reg_flush;
  logic        start;
  logic        sign;
  logic [31:0] source_a;
  logic [31:0] source_b;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;

  always #5 clk = ~clk;

  divalu dut (
    .clk       (clk),
    .rst       (rst),
    .reg_stall (reg_stall),
    .reg_flush (reg_flush),
    .start     (start),
    .sign      (sign),
    .source_a  (source_a),
    .source_b  (source_b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drives a request in cycle T and leaves the bench 1ns into cycle T+1 with
  // start dropped and the operand buses scrambled (they must be latched).
  task automatic launch(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] q, input logic [31:0] r, input bit push);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; sign = sg; source_a = a; source_b = b;
    if (push) begin
      e.q = q; e.r = r;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check("busy_at_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0; sign = 1'($urandom); source_a = $urandom; source_b = $urandom;
  endtask

  // Called 1ns into cycle T+1; returns at the negedge of the done cycle.
  task automatic wait_done(input string name, input int exp_lat);
    int   cyc;
    bit   busy_ok;
    exp_t e;
    cyc = 1; busy_ok = 1'b1;
    @(negedge clk);
    while (!done && cyc < 80) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
      @(negedge clk);
    end
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    check({name, "_busy_low_at_done"}, {31'd0, busy}, 32'd0);
    if (sb_q.size() == 0) begin
      total++;
      $display("FAIL %s_scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sb_q.pop_front();
      check({name, "_quotient"}, quotient, e.q);
      check({name, "_remainder"}, remainder, e.r);
      $display("txn %s: lat=%0d q=%h r=%h (exp q=%h r=%h)", name, cyc, quotient, remainder, e.q, e.r);
    end
  endtask

  initial begin
    logic [31:0] hold_q;
    logic [31:0] hold_r;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        34, "divu_100_7"};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34, "div_m7_2"};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        34, "div_7_m2"};
    vecs[3] = '{1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        34, "divu_max_1"};
    vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        34, "div_ovf"};
    vecs[5] = '{1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1,  "divu_5_0"};
    vecs[6] = '{1'b1, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1,  "div_m7_0"};
    vecs[7] = '{1'b0, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 32'd1,        34, "divu_big_2"};
    vecs[8] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 34, "div_m100_m7"};

    rst = 1'b1; reg_stall = 1'b0; reg_flush = 1'b0; start = 1'b0; sign = 1'b0;
    source_a = '0; source_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);

    // Table: each request launches in the first IDLE cycle after DONE.
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b1);
      wait_done(vecs[i].name, vecs[i].lat);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_done_done", {31'd0, done}, 32'd0);
    check("idle_after_done_busy", {31'd0, busy}, 32'd0);

    // Start coinciding with a flush in IDLE is suppressed.
    @(posedge clk); #1;
    start = 1'b1; reg_flush = 1'b1; sign = 1'b0; source_a = 32'd50; source_b = 32'd5;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; reg_flush = 1'b0;
    @(negedge clk);
    check("flush_start_no_op_busy", {31'd0, busy}, 32'd0);
    check("flush_start_no_op_done", {31'd0, done}, 32'd0);

    // Flush at T+10 abandons a division; restart at T+11.
    launch(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      check("flush_no_done_early", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    reg_flush = 1'b1; start = 1'b1;
    @(negedge clk);
    check("flush_cycle_busy", {31'd0, busy}, 32'd1);
    check("flush_cycle_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reg_flush = 1'b0; start = 1'b0;
    #1;
    check("after_flush_busy", {31'd0, busy}, 32'd0);
    check("after_flush_done", {31'd0, done}, 32'd0);
    start = 1'b1; sign = 1'b0; source_a = 32'd9; source_b = 32'd3;
    begin
      exp_t e;
      e.q = 32'd3; e.r = 32'd0;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check("restart_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("divu_9_3_after_flush", 34);

    // Stall held for 5 cycles in DONE with start high: results hold.
    @(posedge clk); #1;
    launch(1'b0, 32'd1000, 32'd7, 32'd142, 32'd6, 1'b1);
    wait_done("divu_1000_7", 34);
    hold_q = quotient; hold_r = remainder;
    reg_stall = 1'b1; start = 1'b1; sign = 1'b0; source_a = 32'd50; source_b = 32'd5;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_done_held", {31'd0, done}, 32'd1);
      check("stall_busy_low", {31'd0, busy}, 32'd0);
      check("stall_quotient_held", quotient, 32'd142);
      check("stall_remainder_held", remainder, 32'd6);
    end
    @(posedge clk); #1;
    reg_stall = 1'b0; start = 1'b0;
    @(negedge clk);
    check("unstall_done_still", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("unstall_idle_done", {31'd0, done}, 32'd0);
    check("unstall_idle_busy", {31'd0, busy}, 32'd0);
    check("unstall_quotient_kept", quotient, hold_q);
    check("unstall_remainder_kept", remainder, hold_r);
    $display("txn stall_hold: q=%h r=%h", quotient, remainder);

    // Reset at T+20 of a running division.
    launch(1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_quotient", quotient, 32'd0);
    check("rst_mid_remainder", remainder, 32'd0);
    begin
      int seen;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("rst_op_lost", seen, 32'd0);
    end
    $display("txn reset_abort: busy=%0b done=%0b q=%h r=%h", busy, done, quotient, remainder);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
